// File: rtl/latch_fifo_if.sv
// Producer/consumer bundle for latch_fifo: write request, registered read word,
// occupancy and sticky error flags.
interface latch_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       wr_en;
    logic [WIDTH-1:0]           wr_data;
    logic                       rd_en;
    logic [WIDTH-1:0]           rd_data;
    logic                       rd_valid;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/latch_fifo.sv
// Synchronous FIFO of DEPTH x WIDTH words with a registered, holding read port,
// full/empty back-pressure, occupancy count and sticky overflow/underflow flags.
module latch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    latch_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_accept;
    logic             w_rd_accept;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = bus.wr_en && !w_full;
    assign w_rd_accept = bus.rd_en && !w_empty;

    // Storage is never reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wp] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_wr_accept) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rp];
                r_rp      <= r_rp + 1'b1;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_latch_fifo.sv
// Scoreboard bench for latch_fifo (WIDTH=8, DEPTH=4): accepted writes are queued,
// accepted reads pop the expected word, and outputs are sampled 1 ns after each edge.
module tb_latch_fifo;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    latch_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    latch_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] sb [$];
    logic [7:0] m_rd;
    logic       m_valid;
    logic       m_ovf;
    logic       m_unf;

    function automatic logic [2:0] m_count();
        return 3'(sb.size());
    endfunction

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic wa, ra;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        wa = w && (sb.size() != 4);
        ra = r && (sb.size() != 0);
        if (w && !wa) m_ovf = 1'b1;
        if (r && !ra) m_unf = 1'b1;
        m_valid = ra;
        if (ra) m_rd = sb.pop_front();
        if (wa) sb.push_back(d);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        $display("txn wr=%b d=%h rd=%b -> rd_data=%h valid=%b count=%0d ovf=%b unf=%b",
                 w, d, r, bus.rd_data, bus.rd_valid, bus.count, bus.overflow, bus.underflow);
    endtask

    task automatic do_reset(input int edges);
        rst_n = 1'b0;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wr_data = 8'hEE;
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        sb.delete();
        m_rd = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        $display("txn reset for %0d edges", edges);
    endtask

    task automatic test_reset();
        do_reset(2);
        n_vec++; if (bus.rd_data !== 8'h00) begin n_miss++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        n_vec++; if (bus.count !== 3'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_miss++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", bus.empty, bus.full); end
        n_vec++; if (bus.rd_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", bus.rd_valid); end
        n_vec++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_miss++; $display("FAIL reset_err: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] words [4] = '{8'h01, 8'h05, 8'h80, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, words[i], 1'b0);
            n_vec++; if (bus.count !== m_count()) begin n_miss++; $display("FAIL fill_count: got %0d want %0d", bus.count, m_count()); end
        end
        n_vec++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin n_miss++; $display("FAIL fill_full: got full=%b count=%0d want 1 4", bus.full, bus.count); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_vec++; if (bus.rd_data !== m_rd || bus.rd_data !== words[i]) begin n_miss++; $display("FAIL drain_data: got %h want %h", bus.rd_data, words[i]); end
            n_vec++; if (bus.rd_valid !== 1'b1) begin n_miss++; $display("FAIL drain_valid: got %b want 1", bus.rd_valid); end
        end
        step(1'b0, 8'h00, 1'b0);
        n_vec++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'hFF || bus.rd_valid !== 1'b0) begin n_miss++; $display("FAIL drain_hold: got empty=%b rd_data=%h valid=%b want 1 FF 0", bus.empty, bus.rd_data, bus.rd_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] words [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        n_vec++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin n_miss++; $display("FAIL ovf_set: got ovf=%b count=%0d want 1 4", bus.overflow, bus.count); end
        step(1'b0, 8'h00, 1'b0);
        n_vec++; if (bus.overflow !== m_ovf) begin n_miss++; $display("FAIL ovf_sticky: got %b want %b", bus.overflow, m_ovf); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_vec++; if (bus.rd_data !== words[i] || bus.rd_data !== m_rd) begin n_miss++; $display("FAIL ovf_drain: got %h want %h", bus.rd_data, words[i]); end
        end
        n_vec++; if (bus.overflow !== 1'b1 || bus.empty !== 1'b1) begin n_miss++; $display("FAIL ovf_after: got ovf=%b empty=%b want 1 1", bus.overflow, bus.empty); end
    endtask

    task automatic test_underflow();
        logic [7:0] prev;
        do_reset(1);
        step(1'b1, 8'h9D, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        prev = m_rd;
        step(1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.rd_valid !== 1'b0) begin n_miss++; $display("FAIL unf_valid: got %b want 0", bus.rd_valid); end
        n_vec++; if (bus.rd_data !== prev || prev !== 8'h9D) begin n_miss++; $display("FAIL unf_hold: got %h want 9D", bus.rd_data); end
        n_vec++; if (bus.underflow !== 1'b1 || bus.count !== 3'd0) begin n_miss++; $display("FAIL unf_set: got unf=%b count=%0d want 1 0", bus.underflow, bus.count); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] prev;
        do_reset(1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        n_vec++; if (bus.count !== 3'd2 || bus.rd_data !== 8'h11 || bus.rd_valid !== 1'b1) begin n_miss++; $display("FAIL sim_mid: got count=%0d rd_data=%h valid=%b want 2 11 1", bus.count, bus.rd_data, bus.rd_valid); end
        step(1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.rd_data !== m_rd || m_rd !== 8'h22) begin n_miss++; $display("FAIL sim_next1: got %h want 22", bus.rd_data); end
        step(1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.rd_data !== m_rd || m_rd !== 8'h33) begin n_miss++; $display("FAIL sim_next2: got %h want 33", bus.rd_data); end
        prev = m_rd;
        step(1'b1, 8'hAA, 1'b1);
        n_vec++; if (bus.count !== 3'd1 || bus.rd_valid !== 1'b0 || bus.underflow !== 1'b1) begin n_miss++; $display("FAIL sim_empty: got count=%0d valid=%b unf=%b want 1 0 1", bus.count, bus.rd_valid, bus.underflow); end
        n_vec++; if (bus.rd_data !== prev) begin n_miss++; $display("FAIL sim_nobypass: got %h want %h", bus.rd_data, prev); end
        step(1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.rd_data !== 8'hAA || bus.rd_data !== m_rd) begin n_miss++; $display("FAIL sim_aa: got %h want AA", bus.rd_data); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            d = 8'(i * 8'h11);
            step(1'b1, d, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            n_vec++; if (bus.rd_data !== d || bus.rd_data !== m_rd || bus.rd_valid !== 1'b1) begin n_miss++; $display("FAIL wrap_%0d: got %h valid=%b want %h 1", i, bus.rd_data, bus.rd_valid, d); end
        end
    endtask

    task automatic test_midop_reset();
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        n_vec++; if (bus.count !== 3'd3) begin n_miss++; $display("FAIL mid_pre: got count=%0d want 3", bus.count); end
        do_reset(1);
        n_vec++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_miss++; $display("FAIL mid_reset: got count=%0d empty=%b want 0 1", bus.count, bus.empty); end
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_vec++; if (bus.rd_data !== 8'h5A || bus.rd_data !== m_rd || bus.empty !== 1'b1) begin n_miss++; $display("FAIL mid_new: got %h empty=%b want 5A 1", bus.rd_data, bus.empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
